// File: rtl/knn_dist_calc.sv
// Squared-Euclidean distance stage feeding the k-NN insertion list.
// Define KNN_DIST_PIPE_EN to split squaring and sum/saturate into separate stages (latency 3 instead of 2).
module knn_dist_calc #(
  parameter int COORD_W = 16,
  parameter int DATA_W  = 32,
  parameter int LABEL   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_points,
  input  logic [COORD_W-1:0] test_x,
  input  logic [COORD_W-1:0] test_y,
  input  logic [COORD_W-1:0] train_x,
  input  logic [COORD_W-1:0] train_y,
  input  logic [LABEL-1:0]   train_label,
  input  logic               train_valid,
  output logic [DATA_W-1:0]  Dist_candidate,
  output logic [LABEL-1:0]   label_candidate,
  output logic               valid,
  output logic [CNT_W-1:0]   out_count,
  output logic               busy,
  output logic               done
);

  localparam int DW    = COORD_W + 1;
  localparam int SQ_W  = 2 * DW;
  localparam int SUM_W = SQ_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]         n_reg, in_count_reg, out_count_reg;
  logic [1:0][COORD_W-1:0]  test_reg, train_pt;
  logic [1:0][DW-1:0]       d_next, d_reg;
  logic [1:0][SQ_W-1:0]     sq;
  logic [LABEL-1:0]         s1_label_reg;
  logic                     s1_valid_reg;
  logic [SUM_W-1:0]         sum_sq;
  logic [DATA_W-1:0]        dist_sat;
  logic [LABEL-1:0]         fin_label;
  logic                     fin_valid;
  logic                     accept, emit;

  // Index 0 is the x axis, index 1 the y axis.
  assign train_pt = {train_y, train_x};

  assign accept = (state_reg == RUN) && train_valid && (in_count_reg < n_reg) && !start;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic signed [SQ_W-1:0] d_ext;
      assign d_next[gi] = $signed({train_pt[gi][COORD_W-1], train_pt[gi]})
                        - $signed({test_reg[gi][COORD_W-1], test_reg[gi]});
      assign d_ext      = {{(SQ_W-DW){d_reg[gi][DW-1]}}, d_reg[gi]};
      assign sq[gi]     = d_ext * d_ext;
    end
  endgenerate

`ifdef KNN_DIST_PIPE_EN
  logic [1:0][SQ_W-1:0] sq_reg;
  logic [LABEL-1:0]     s2_label_reg;
  logic                 s2_valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_reg       <= '0;
      s2_label_reg <= '0;
      s2_valid_reg <= 1'b0;
    end else if (start) begin
      s2_valid_reg <= 1'b0;
    end else begin
      sq_reg       <= sq;
      s2_label_reg <= s1_label_reg;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  assign sum_sq    = {1'b0, sq_reg[0]} + {1'b0, sq_reg[1]};
  assign fin_label = s2_label_reg;
  assign fin_valid = s2_valid_reg;
`else
  assign sum_sq    = {1'b0, sq[0]} + {1'b0, sq[1]};
  assign fin_label = s1_label_reg;
  assign fin_valid = s1_valid_reg;
`endif

  assign dist_sat = (|sum_sq[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : sum_sq[DATA_W-1:0];
  assign emit     = fin_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      n_reg           <= '0;
      in_count_reg    <= '0;
      out_count_reg   <= '0;
      test_reg        <= '0;
      d_reg           <= '0;
      s1_label_reg    <= '0;
      s1_valid_reg    <= 1'b0;
      Dist_candidate  <= '0;
      label_candidate <= '0;
      valid           <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        // Restart drops every in-flight result.
        n_reg         <= n_points;
        test_reg      <= {test_y, test_x};
        in_count_reg  <= '0;
        out_count_reg <= '0;
        s1_valid_reg  <= 1'b0;
        valid         <= 1'b0;
      end else begin
        s1_valid_reg <= accept;
        if (accept) begin
          d_reg        <= d_next;
          s1_label_reg <= train_label;
          in_count_reg <= in_count_reg + CNT_W'(1);
        end
        valid <= emit;
        if (emit) begin
          Dist_candidate  <= dist_sat;
          label_candidate <= fin_label;
          if (out_count_reg < n_reg) out_count_reg <= out_count_reg + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg == RUN) || (state_reg == DRAIN);
    done       = (state_reg == DONE);
    if (start) begin
      state_next = (n_points == '0) ? DONE : RUN;
    end else begin
      case (state_reg)
        RUN:     if (accept && (in_count_reg + CNT_W'(1) == n_reg)) state_next = DRAIN;
        DRAIN:   if (emit && (out_count_reg + CNT_W'(1) == n_reg)) state_next = DONE;
        default: ;
      endcase
    end
  end

  assign out_count = out_count_reg;

endmodule

// File: tb/tb_knn_dist_calc.sv
// Randomized check of knn_dist_calc against a queue-based reference model.
// Honours KNN_DIST_PIPE_EN to pick the expected latency.
module tb_knn_dist_calc;

`ifdef KNN_DIST_PIPE_EN
  localparam int L = 3;
`else
  localparam int L = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_points = '0;
  logic [15:0] test_x = '0, test_y = '0, train_x = '0, train_y = '0;
  logic [7:0]  train_label = '0;
  logic        train_valid = 1'b0;
  logic [31:0] Dist_candidate;
  logic [7:0]  label_candidate;
  logic        valid;
  logic [15:0] out_count;
  logic        busy, done;

  knn_dist_calc dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points),
    .test_x(test_x), .test_y(test_y), .train_x(train_x), .train_y(train_y),
    .train_label(train_label), .train_valid(train_valid),
    .Dist_candidate(Dist_candidate), .label_candidate(label_candidate),
    .valid(valid), .out_count(out_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  l;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          total = 0, bad = 0, cyc = 0;
  int          mdl_n = 0, mdl_in = 0, mdl_out = 0, vcount = 0;
  int          mdl_tx = 0, mdl_ty = 0;
  bit          started = 1'b0;
  logic [31:0] last_dist = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_dist(input int tx, input int ty, input int x, input int y);
    longint dx, dy, s;
    dx = longint'(x) - longint'(tx);
    dy = longint'(y) - longint'(ty);
    s  = dx * dx + dy * dy;
    return (s > 64'sd4294967295) ? 32'hFFFF_FFFF : 32'(s);
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: every valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      chk("valid_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dist", 64'(Dist_candidate), 64'(e.d));
        chk("label", 64'(label_candidate), 64'(e.l));
        chk("latency_cycle", 64'(cyc), 64'(e.c));
        mdl_out++;
        last_dist = Dist_candidate;
      end
    end
    chk("out_count", 64'(out_count), 64'(mdl_out));
    chk("done", 64'(done), 64'(started && (mdl_out == mdl_n)));
    chk("busy", 64'(busy), 64'(started && (mdl_out != mdl_n)));
  end

  // One cycle of training input; unrelated start-time inputs carry noise.
  task automatic drive(input bit tv, input int x, input int y, input int lbl);
    int k;
    bit acc;
    train_valid = tv;
    train_x     = 16'(x);
    train_y     = 16'(y);
    train_label = 8'(lbl);
    n_points    = 16'($urandom);
    test_x      = 16'($urandom);
    test_y      = 16'($urandom);
    k   = cyc;
    acc = tv && started && (mdl_in < mdl_n);
    @(posedge clk);
    if (acc) begin
      exp_q.push_back('{ref_dist(mdl_tx, mdl_ty, x, y), 8'(lbl), k + L});
      mdl_in++;
    end
    #1;
  endtask

  task automatic do_start(input int n, input int tx, input int ty);
    start       = 1'b1;
    n_points    = 16'(n);
    test_x      = 16'(tx);
    test_y      = 16'(ty);
    train_valid = 1'b1;
    train_x     = 16'($urandom);
    train_y     = 16'($urandom);
    @(posedge clk);
    exp_q.delete();
    mdl_n   = n;
    mdl_in  = 0;
    mdl_out = 0;
    mdl_tx  = tx;
    mdl_ty  = ty;
    started = 1'b1;
    vcount  = 0;
    #1;
    start       = 1'b0;
    train_valid = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int i;
    i = 0;
    while (done !== 1'b1 && i < max) begin
      drive(1'b0, 0, 0, 0);
      i++;
    end
    chk("done_within_bound", 64'(done), 64'd1);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held: inputs toggle, outputs stay at zero.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start       = 1'($urandom);
      train_valid = 1'($urandom);
      n_points    = 16'($urandom);
      test_x      = 16'($urandom);
      test_y      = 16'($urandom);
      train_x     = 16'($urandom);
      train_y     = 16'($urandom);
      train_label = 8'($urandom);
      @(negedge clk);
      chk("rst_dist", 64'(Dist_candidate), 64'd0);
      chk("rst_label", 64'(label_candidate), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
    end
    @(posedge clk);
    #1;
    start       = 1'b0;
    train_valid = 1'b0;
    rst         = 1'b1;
    drive(1'b0, 0, 0, 0);

    // Basic 3-4-5 point with exact latency.
    do_start(1, 0, 0);
    drive(1'b1, 3, 4, 5);
    repeat (L - 1) drive(1'b0, 0, 0, 0);
    chk("t2_valid", 64'(valid), 64'd1);
    chk("t2_dist", 64'(Dist_candidate), 64'd25);
    chk("t2_label", 64'(label_candidate), 64'd5);
    chk("t2_done", 64'(done), 64'd1);
    wait_done(4);

    // Saturation at the extreme corners.
    do_start(1, -32768, -32768);
    drive(1'b1, 32767, 32767, 8'hA5);
    wait_done(10);
    chk("t3_sat", 64'(last_dist), 64'hFFFF_FFFF);

    // Six back-to-back points, only four accepted.
    do_start(4, rnd16(), rnd16());
    for (int i = 0; i < 6; i++) drive(1'b1, rnd16(), rnd16(), int'($urandom_range(0, 255)));
    wait_done(10);
    chk("t4_vcount", 64'(vcount), 64'd4);
    chk("t4_out_count", 64'(out_count), 64'd4);

    // Restart mid-run.
    do_start(4, rnd16(), rnd16());
    drive(1'b1, rnd16(), rnd16(), 1);
    drive(1'b1, rnd16(), rnd16(), 2);
    do_start(1, 1, 1);
    drive(1'b1, 1, 2, 9);
    wait_done(10);
    chk("t5_vcount", 64'(vcount), 64'd1);
    chk("t5_out_count", 64'(out_count), 64'd1);
    chk("t5_dist", 64'(last_dist), 64'd1);

    // Empty run.
    do_start(0, rnd16(), rnd16());
    chk("t6_done_next", 64'(done), 64'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, rnd16(), rnd16(), 7);
    chk("t6_done_hold", 64'(done), 64'd1);
    chk("t6_vcount", 64'(vcount), 64'd0);

    // Random runs, some cut short by the next start.
    for (int r = 0; r < 30; r++) begin
      bit cut;
      int n;
      n   = int'($urandom_range(1, 8));
      cut = ($urandom_range(0, 4) == 0);
      do_start(n, rnd16(), rnd16());
      for (int j = 0; j < n + 2; j++) begin
        drive(($urandom_range(0, 3) != 0), rnd16(), rnd16(), int'($urandom_range(0, 255)));
        if (cut && j == 1) break;
      end
      if (!cut) begin
        for (int j = 0; j < 16 && mdl_in < mdl_n; j++)
          drive(1'b1, rnd16(), rnd16(), int'($urandom_range(0, 255)));
        wait_done(10);
        chk("rand_vcount", 64'(vcount), 64'(n));
      end
    end

    // Asynchronous reset in the middle of a run.
    do_start(5, rnd16(), rnd16());
    for (int i = 0; i < 3; i++) drive(1'b1, rnd16(), rnd16(), int'($urandom_range(0, 255)));
    rst = 1'b0;
    exp_q.delete();
    started = 1'b0;
    mdl_n   = 0;
    mdl_in  = 0;
    mdl_out = 0;
    #1;
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_out_count", 64'(out_count), 64'd0);
    chk("arst_dist", 64'(Dist_candidate), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, rnd16(), rnd16(), 3);
    do_start(2, rnd16(), rnd16());
    drive(1'b1, rnd16(), rnd16(), 11);
    drive(1'b1, rnd16(), rnd16(), 12);
    wait_done(10);
    chk("arst_recover_vcount", 64'(vcount), 64'd2);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
